csr_tohost_unit: RTL

//  CPU-side CSR unit: the writer of the tohost status word that simulation

---
 rtl/csr_tohost_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/csr_tohost_unit.sv
// csr_tohost_unit: execute-stage Zicsr unit owning the tohost status word
// and the read-only 64-bit cycle/instret counters. One-cycle read latency;
// tohost and the counters update at the edge where an op is accepted.
module csr_tohost_unit #(
   parameter logic [11:0] TOHOST_ADDR = 12'h51E,
   parameter int          COUNTER_W   = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        csr_valid,
   input  logic [2:0]  csr_funct3,
   input  logic [11:0] csr_addr,
   input  logic [4:0]  csr_rs1_field,
   input  logic [31:0] csr_rs1_data,
   input  logic        instr_retire,
   output logic [31:0] csr_rdata,
   output logic        csr_rdata_vld,
   output logic        csr_illegal,
   output logic [31:0] tohost,
   output logic        done,
   output logic        pass,
   output logic [30:0] fail_id
);

   localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
   localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
   localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
   localparam logic [11:0] ADDR_INSTRETH = 12'hC82;

   // funct3[1:0] selects the operation; funct3[2] selects the immediate form.
   localparam logic [1:0] OP_RW = 2'b01;
   localparam logic [1:0] OP_RS = 2'b10;
   localparam logic [1:0] OP_RC = 2'b11;

   logic [COUNTER_W-1:0] cycle_cnt;
   logic [COUNTER_W-1:0] instret_cnt;

   logic        acc_p0;
   logic        we_p0;
   logic        mapped_p0;
   logic        sel_tohost_p0;
   logic        illegal_p0;
   logic [31:0] src_p0;
   logic [31:0] old_p0;
   logic [31:0] new_p0;

   // Read-modify-write value for RW/RS/RC; unused encodings leave it alone.
   function automatic logic [31:0] csr_new_val(input logic [1:0] op,
                                               input logic [31:0] old_val,
                                               input logic [31:0] src);
      case (op)
         OP_RW:   csr_new_val = src;
         OP_RS:   csr_new_val = old_val | src;
         OP_RC:   csr_new_val = old_val & ~src;
         default: csr_new_val = old_val;
      endcase
   endfunction

   // Stage p0: decode the op, read the old value and form the write value.
   always_comb begin
      acc_p0        = csr_valid && !stall && !rst;
      src_p0        = csr_funct3[2] ? {27'd0, csr_rs1_field} : csr_rs1_data;
      // RS/RC with x0/zimm=0 are pure reads and must not count as writes,
      // otherwise a plain csrr of a counter would trap.
      we_p0         = (csr_funct3[1:0] == OP_RW) ||
                      (csr_funct3[1] && (csr_rs1_field != 5'd0));
      sel_tohost_p0 = (csr_addr == TOHOST_ADDR);
      mapped_p0     = 1'b1;
      case (csr_addr)
         TOHOST_ADDR:   old_p0 = tohost;
         ADDR_CYCLE:    old_p0 = cycle_cnt[31:0];
         ADDR_CYCLEH:   old_p0 = cycle_cnt[63:32];
         ADDR_INSTRET:  old_p0 = instret_cnt[31:0];
         ADDR_INSTRETH: old_p0 = instret_cnt[63:32];
         default: begin
            old_p0    = 32'd0;
            mapped_p0 = 1'b0;
         end
      endcase
      illegal_p0 = !mapped_p0 || (we_p0 && !sel_tohost_p0);
      new_p0     = csr_new_val(csr_funct3[1:0], old_p0, src_p0);
   end

   // Stage p1: register the pre-write value and the response pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         csr_rdata     <= 32'd0;
         csr_rdata_vld <= 1'b0;
         csr_illegal   <= 1'b0;
      end else begin
         csr_rdata_vld <= acc_p0;
         csr_illegal   <= acc_p0 && illegal_p0;
         if (acc_p0) begin
            csr_rdata <= old_p0;
         end
      end
   end

   // tohost write at the accept edge; illegal ops never reach here because
   // tohost itself is always mapped and writable.
   always_ff @(posedge clk) begin
      if (rst) begin
         tohost <= 32'd0;
      end else if (acc_p0 && we_p0 && sel_tohost_p0 && !illegal_p0) begin
         tohost <= new_p0;
      end
   end

   // Free-running cycle counter; keeps counting through stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + COUNTER_W'(1);
      end
   end

   // Retired-instruction counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         instret_cnt <= '0;
      end else if (instr_retire) begin
         instret_cnt <= instret_cnt + COUNTER_W'(1);
      end
   end

   assign done    = tohost[0];
   assign fail_id = tohost[31:1];
   assign pass    = tohost[0] && (tohost[31:1] == 31'd0);

endmodule
